// File: rtl/id_control_sequencer_pkg.sv
// rtl/id_control_sequencer_pkg.sv - shared opcodes, immediate types, FSM states and bundle type
package id_control_sequencer_pkg;

  localparam logic [6:0] OPC_NOP    = 7'b0000000;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // imm_sel = {unsigned_flag, type}
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] M_ALU_OP = 2'b01;
  localparam logic [2:0] BJ_JUMP  = 3'b010;
  localparam int         CNT_W    = $clog2(64 + 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MDWAIT = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu_op;
    logic       reg_write_en;
    logic [2:0] mem_write;
    logic [3:0] mem_read;
    logic [3:0] branch_jump;
    logic [3:0] imm_sel;
    logic       data1_alu_sel;
    logic       data2_alu_sel;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/id_control_sequencer_decode.sv
// rtl/id_control_sequencer_decode.sv - combinational instr-to-bundle decode with illegal detection
module ctrl_decode_comb
  import id_control_sequencer_pkg::*;
#(
  parameter bit M_EXT = 1'b1
) (
  input  logic         in_valid,
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         is_mop
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       bad;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    bundle = '0;
    is_mop = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        bundle.alu_op  = {2'b11, funct3};
        bundle.imm_sel = {1'b0, IMM_U};
      end
      OPC_AUIPC: begin
        bundle.data1_alu_sel = 1'b1;
        bundle.imm_sel       = {1'b0, IMM_U};
      end
      OPC_JAL: begin
        bundle.data1_alu_sel = 1'b1;
        bundle.imm_sel       = {1'b0, IMM_J};
        bundle.branch_jump   = {1'b1, BJ_JUMP};
      end
      OPC_JALR: begin
        bundle.alu_op        = {2'b00, funct3};
        bundle.data1_alu_sel = 1'b1;
        bundle.imm_sel       = {1'b0, IMM_I};
        bundle.branch_jump   = {1'b1, BJ_JUMP};
      end
      OPC_BRANCH: begin
        bundle.data1_alu_sel = 1'b1;
        bundle.imm_sel       = {funct3[2] & funct3[1], IMM_B};
        bundle.branch_jump   = {1'b1, funct3};
      end
      OPC_LOAD: begin
        bundle.imm_sel  = {funct3[2] & ~funct3[1], IMM_I};
        bundle.mem_read = {1'b1, funct3};
      end
      OPC_STORE: begin
        bundle.imm_sel   = {1'b0, IMM_S};
        bundle.mem_write = {1'b1, funct3[1:0]};
      end
      OPC_OP_IMM: begin
        bundle.alu_op  = {(funct3 == 3'b101) && instr[30], 1'b0, funct3};
        bundle.imm_sel = {funct3 == 3'b011, IMM_I};
      end
      OPC_OP: begin
        if (funct7 == F7_MEXT) begin
          bad           = !M_EXT;
          is_mop        = M_EXT;
          bundle.alu_op = {M_ALU_OP, funct3};
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          bundle.alu_op = {(funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101), 1'b0, funct3};
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    bundle.valid         = 1'b1;
    bundle.reg_write_en  = (opcode != OPC_STORE) && (opcode != OPC_BRANCH);
    bundle.data2_alu_sel = (opcode != OPC_OP);
    bundle.wb_sel        = {(opcode == OPC_LUI) || (opcode == OPC_JAL) || (opcode == OPC_JALR),
                            !((opcode == OPC_LOAD) || (opcode == OPC_LUI))};

    // Illegal ops still occupy a slot so the trap logic downstream sees them.
    if (bad) begin
      bundle         = '0;
      bundle.valid   = 1'b1;
      bundle.illegal = 1'b1;
      is_mop         = 1'b0;
    end
    if (!in_valid || opcode == OPC_NOP) begin
      bundle = '0;
      is_mop = 1'b0;
    end
  end

endmodule

// File: rtl/id_control_sequencer.sv
// rtl/id_control_sequencer.sv - registered decode stage with flush/stall and MUL/DIV wait sequencing
module id_control_sequencer
  import id_control_sequencer_pkg::*;
#(
  parameter bit M_EXT      = 1'b1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        out_valid,
  output logic [4:0]  alu_op,
  output logic        reg_write_en,
  output logic [2:0]  mem_write,
  output logic [3:0]  mem_read,
  output logic [3:0]  branch_jump,
  output logic [3:0]  imm_sel,
  output logic        data1_alu_sel,
  output logic        data2_alu_sel,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        stall_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MUL_WAIT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_WAIT = CNT_W'(DIV_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] mop_wait;
  ctrl_bundle_t     dec, q, q_nxt;
  logic             dec_mop;

  ctrl_decode_comb #(.M_EXT(M_EXT)) u_decode (
    .in_valid (in_valid),
    .instr    (instr),
    .bundle   (dec),
    .is_mop   (dec_mop)
  );

  // funct3[2] splits the M-ops into the MUL and DIV latency classes
  assign mop_wait = instr[14] ? DIV_WAIT : MUL_WAIT;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = '0;
    case (state)
      ST_RUN: begin
        if (!flush && !stall_in) begin
          q_nxt = dec;
          if (dec_mop && mop_wait != '0) begin
            state_nxt = ST_MDWAIT;
            cnt_nxt   = mop_wait;
          end
        end
      end
      ST_MDWAIT: begin
        // The M-op is already in EX, so flush/stall_in cannot cancel the wait.
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
    end
  end

  assign out_valid     = q.valid;
  assign alu_op        = q.alu_op;
  assign reg_write_en  = q.reg_write_en;
  assign mem_write     = q.mem_write;
  assign mem_read      = q.mem_read;
  assign branch_jump   = q.branch_jump;
  assign imm_sel       = q.imm_sel;
  assign data1_alu_sel = q.data1_alu_sel;
  assign data2_alu_sel = q.data2_alu_sel;
  assign wb_sel        = q.wb_sel;
  assign illegal       = q.illegal;
  assign stall_out     = (state == ST_MDWAIT);
  assign busy          = (state == ST_MDWAIT);

endmodule

// File: tb/tb_id_control_sequencer.sv
// tb/tb_id_control_sequencer.sv - three-configuration bench against a behavioural decode/latency model
module tb_id_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall_in, flush;
  logic [31:0] instr;

  always #5 clk = ~clk;

  logic       ov[3], rwe[3], d1s[3], d2s[3], ill[3], so[3], bz[3];
  logic [4:0] aop[3];
  logic [2:0] mw[3];
  logic [3:0] mr[3], bj[3], imm[3];
  logic [1:0] wb[3];
  logic [28:0] obs[3];
  logic [28:0] exp_v[3];
  int          busy_until[3];
  int          edge_no = 0;
  int          checks = 0;
  int          errors = 0;

  // cfg0: M on, MUL 1, DIV 4   cfg1: M off   cfg2: M on, MUL 3, DIV 2
  function automatic bit cfg_mext(input int c); return c != 1; endfunction
  function automatic int cfg_mul(input int c); return (c == 2) ? 3 : 1; endfunction
  function automatic int cfg_div(input int c); return (c == 2) ? 2 : 4; endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_control_sequencer #(
      .M_EXT(g != 1), .MUL_CYCLES((g == 2) ? 3 : 1), .DIV_CYCLES((g == 2) ? 2 : 4)
    ) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
      .stall_in(stall_in), .flush(flush), .out_valid(ov[g]), .alu_op(aop[g]),
      .reg_write_en(rwe[g]), .mem_write(mw[g]), .mem_read(mr[g]), .branch_jump(bj[g]),
      .imm_sel(imm[g]), .data1_alu_sel(d1s[g]), .data2_alu_sel(d2s[g]), .wb_sel(wb[g]),
      .illegal(ill[g]), .stall_out(so[g]), .busy(bz[g])
    );
    assign obs[g] = {ov[g], aop[g], rwe[g], mw[g], mr[g], bj[g], imm[g],
                     d1s[g], d2s[g], wb[g], ill[g], so[g], bz[g]};
  end

  // Table of architectural meaning per opcode; lat_class 1 = MUL group, 2 = DIV group.
  function automatic logic [26:0] ref_decode(input bit mext, input logic [31:0] ins,
                                             output int lat_class);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] alu;
    logic [2:0] wmem;
    logic [3:0] rmem, brj, isel;
    logic       wen, pc_sel, imm_used, legal;
    logic [1:0] wbs;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    alu = 0; wmem = 0; rmem = 0; brj = 0; isel = 0;
    wen = 1; pc_sel = 0; imm_used = 1; wbs = 2'b01; legal = 1;
    lat_class = 0;
    case (op)
      7'b0110111: begin alu = {2'b11, f3}; isel = 4'd4; wbs = 2'b10; end
      7'b0010111: begin pc_sel = 1; isel = 4'd4; end
      7'b1101111: begin pc_sel = 1; isel = 4'd5; brj = 4'b1010; wbs = 2'b11; end
      7'b1100111: begin alu = {2'b00, f3}; pc_sel = 1; isel = 4'd1; brj = 4'b1010; wbs = 2'b11; end
      7'b1100011: begin pc_sel = 1; isel = {f3 >= 3'd6, 3'd3}; brj = {1'b1, f3}; wen = 0; end
      7'b0000011: begin isel = {f3 == 3'd4 || f3 == 3'd5, 3'd1}; rmem = {1'b1, f3}; wbs = 2'b00; end
      7'b0100011: begin isel = 4'd2; wmem = {1'b1, f3[1:0]}; wen = 0; end
      7'b0010011: begin alu = {f3 == 3'd5 && ins[30], 1'b0, f3}; isel = {f3 == 3'd3, 3'd1}; end
      7'b0110011: begin
        imm_used = 0;
        if (f7 == 7'd1) begin
          legal = mext; alu = {2'b01, f3}; lat_class = f3[2] ? 2 : 1;
        end else if (f7 == 7'd0) alu = {2'b00, f3};
        else if (f7 == 7'd32) alu = {f3 == 3'd0 || f3 == 3'd5, 1'b0, f3};
        else legal = 0;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      lat_class = 0;
      return {1'b1, 25'd0, 1'b1};
    end
    return {1'b1, alu, wen, wmem, rmem, brj, isel, pc_sel, imm_used, wbs, 1'b0};
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      logic [26:0] b;
      int lc, lat;
      if (reset) begin
        exp_v[c] = '0; busy_until[c] = -1;
      end else if (edge_no <= busy_until[c]) begin
        exp_v[c] = {27'd0, edge_no < busy_until[c], edge_no < busy_until[c]};
      end else if (flush || stall_in || !in_valid || instr[6:0] == 7'd0) begin
        exp_v[c] = '0;
      end else begin
        b = ref_decode(cfg_mext(c), instr, lc);
        lat = (lc == 1) ? cfg_mul(c) : (lc == 2) ? cfg_div(c) : 1;
        if (lat > 1) busy_until[c] = edge_no + lat - 1;
        exp_v[c] = {b, lat > 1, lat > 1};
      end
    end
    edge_no++;
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] i,
                      input logic st, input logic fl);
    reset = r; in_valid = v; instr = i; stall_in = st; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      assert (obs[c] === exp_v[c]) else begin
        errors++;
        $error("FAIL cfg%0d edge%0d bundle observed=%h expected=%h", c, edge_no, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 11);
    case (k)
      0: r[6:0] = 7'b0110111;
      1: r[6:0] = 7'b0010111;
      2: r[6:0] = 7'b1101111;
      3: r[6:0] = 7'b1100111;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b0000011;
      6: r[6:0] = 7'b0100011;
      7: r[6:0] = 7'b0010011;
      8: begin
        r[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'd0;
          1: r[31:25] = 7'd32;
          2: r[31:25] = 7'd1;
          default: ;
        endcase
      end
      9: begin r[6:0] = 7'b0110011; r[31:25] = 7'd1; end
      10: r = 32'd0;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_DIV = 32'h0220C0B3;
  localparam logic [31:0] I_MUL = 32'h022080B3;
  localparam logic [31:0] I_LW  = 32'h0000A083;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  initial begin
    for (int c = 0; c < 3; c++) busy_until[c] = -1;
    step(1, 0, 0, 0, 0);
    step(1, 1, I_ADD, 0, 0);
    chk("reset_cfg0", {3'd0, obs[0]}, 32'd0);

    step(0, 1, I_ADD, 0, 0);
    chk("add_valid", {31'd0, ov[0]}, 32'd1);
    chk("add_alu", {27'd0, aop[0]}, 32'd0);
    chk("add_rwe", {31'd0, rwe[0]}, 32'd1);
    chk("add_wb", {30'd0, wb[0]}, 32'd1);
    chk("add_d2", {31'd0, d2s[0]}, 32'd0);
    chk("add_stall", {31'd0, so[0]}, 32'd0);

    step(0, 1, I_DIV, 0, 0);
    chk("div_alu", {27'd0, aop[0]}, 32'b01100);
    chk("div_valid", {31'd0, ov[0]}, 32'd1);
    chk("div_m_off_illegal", {31'd0, ill[1]}, 32'd1);
    step(0, 1, I_ADD, 0, 1);
    chk("div_wait_bubble", {31'd0, ov[0]}, 32'd0);
    chk("div_wait_busy", {31'd0, bz[0]}, 32'd1);
    step(0, 1, I_ADD, 1, 0);
    chk("div_wait_stall2", {31'd0, so[0]}, 32'd1);
    step(0, 1, I_ADD, 0, 0);
    chk("div_end_stall", {31'd0, so[0]}, 32'd0);
    step(0, 1, I_ADD, 0, 0);
    chk("div_follower", {31'd0, ov[0]}, 32'd1);

    step(0, 1, I_MUL, 0, 0);
    chk("mul_alu", {27'd0, aop[0]}, 32'b01000);
    chk("mul_no_stall", {31'd0, so[0]}, 32'd0);
    chk("mul_m_off_illegal", {31'd0, ill[1]}, 32'd1);
    chk("mul_m_off_rwe", {31'd0, rwe[1]}, 32'd0);
    for (int k = 0; k < 4; k++) step(0, 1, 32'd0, 0, 0);

    step(0, 1, I_BAD, 0, 0);
    chk("bad_illegal", {30'd0, ov[0], ill[0]}, 32'd3);
    chk("bad_ctrl", {25'd0, mw[0], bj[0]}, 32'd0);

    step(0, 1, I_LW, 0, 1);
    chk("lw_flush", {31'd0, ov[0]}, 32'd0);
    step(0, 1, I_LW, 1, 0);
    chk("lw_stall", {31'd0, ov[0]}, 32'd0);
    step(0, 1, I_LW, 0, 0);
    chk("lw_mem_read", {28'd0, mr[0]}, 32'b1010);
    chk("lw_wb", {30'd0, wb[0]}, 32'd0);

    step(0, 1, I_DIV, 0, 0);
    step(0, 1, I_ADD, 0, 0);
    step(1, 1, I_ADD, 0, 0);
    chk("mid_reset_outputs", {3'd0, obs[0]}, 32'd0);
    step(0, 1, I_ADD, 0, 0);
    chk("after_reset_accept", {31'd0, ov[0]}, 32'd1);

    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, rand_instr(),
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
